// File: rtl/id_decode_stage_pkg.sv
// Shared constants for the ID stage: datapath sizes, instruction field positions,
// opcode/funct values, ALU operation encodings and the opcode/funct decoder.
package id_decode_stage_pkg;

   localparam int DSIZE = 32;
   localparam int ASIZE = 5;
   localparam int NREG  = 1 << ASIZE;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int FN_LSB  = 0;
   localparam int IMM_LSB = 0;
   localparam int OPC_W   = 6;
   localparam int FN_W    = 6;
   localparam int IMM_W   = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOR = 3'd5,
      ALU_SLT = 3'd6
   } aluop_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef struct packed {
      logic   legal;
      logic   is_r;
      aluop_e aluop;
   } dec_t;

   function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
      dec_t d;
      d.legal = 1'b1;
      d.is_r  = 1'b0;
      d.aluop = ALU_ADD;
      if (opcode == OP_RTYPE) begin
         d.is_r = 1'b1;
         case (funct)
            FN_ADD:  d.aluop = ALU_ADD;
            FN_SUB:  d.aluop = ALU_SUB;
            FN_AND:  d.aluop = ALU_AND;
            FN_OR:   d.aluop = ALU_OR;
            FN_XOR:  d.aluop = ALU_XOR;
            FN_NOR:  d.aluop = ALU_NOR;
            FN_SLT:  d.aluop = ALU_SLT;
            default: d.legal = 1'b0;
         endcase
      end else begin
         case (opcode)
            OP_ADDI: d.aluop = ALU_ADD;
            OP_ANDI: d.aluop = ALU_AND;
            OP_ORI:  d.aluop = ALU_OR;
            OP_XORI: d.aluop = ALU_XOR;
            OP_SLTI: d.aluop = ALU_SLT;
            default: d.legal = 1'b0;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write port;
// r0 is hardwired to zero and ignores writes.
module regfile_2r1w
   import id_decode_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [ASIZE-1:0] raddr1_i,
   input  logic [ASIZE-1:0] raddr2_i,
   output logic [DSIZE-1:0] rdata1_o,
   output logic [DSIZE-1:0] rdata2_o
);

   logic [DSIZE-1:0] word [NREG];

   genvar gi;
   for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign word[gi] = '0;
      end else begin : g_word
         logic [DSIZE-1:0] word_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_q <= '0;
            end else if (we_i && waddr_i == ASIZE'(gi)) begin
               word_q <= wdata_i;
            end
         end
         assign word[gi] = word_q;
      end
   end

   assign rdata1_o = word[raddr1_i];
   assign rdata2_o = word[raddr2_i];

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode with register file, writeback port and per-register pending scoreboard.
// Define WB_BYPASS_EN to forward the retiring writeback into reads and the hazard check.
module id_decode_stage
   import id_decode_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             wb_wen,
   input  logic [ASIZE-1:0] wb_waddr,
   input  logic [DSIZE-1:0] wb_wdata,
   output logic [2:0]       aluop_cntrl,
   output logic             alusrc_cntrl,
   output logic [DSIZE-1:0] rdata1,
   output logic [DSIZE-1:0] rdata2,
   output logic [DSIZE-1:0] signextender,
   output logic [ASIZE-1:0] waddr,
   output logic             illegal_op
);

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [OPC_W-1:0] opcode;
   logic [FN_W-1:0]  funct;
   logic [ASIZE-1:0] rs, rt, rd, dst;
   logic [DSIZE-1:0] rf_rd1, rf_rd2, op1, op2, sext;
   dec_t             dec;

   assign opcode = instr[OPC_LSB +: OPC_W];
   assign funct  = instr[FN_LSB +: FN_W];
   assign rs     = instr[RS_LSB +: ASIZE];
   assign rt     = instr[RT_LSB +: ASIZE];
   assign rd     = instr[RD_LSB +: ASIZE];
   assign dec    = decode(opcode, funct);
   assign dst    = dec.is_r ? rd : rt;
   assign sext   = {{(DSIZE-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};

   regfile_2r1w u_regfile (
      .clk      (clk),
      .rst_n    (rst),
      .we_i     (wb_wen),
      .waddr_i  (wb_waddr),
      .wdata_i  (wb_wdata),
      .raddr1_i (rs),
      .raddr2_i (rt),
      .rdata1_o (rf_rd1),
      .rdata2_o (rf_rd2)
   );

   assign op1 = (BYPASS && wb_wen && wb_waddr == rs && rs != '0) ? wb_wdata : rf_rd1;
   assign op2 = (BYPASS && wb_wen && wb_waddr == rt && rt != '0) ? wb_wdata : rf_rd2;

   logic [1:0] cnt_q [NREG];
   logic [1:0] cnt_d [NREG];
   logic       illegal_q, illegal_d;
   logic       rs_busy, rt_busy, hazard, issue, fire;

   // A retiring write only frees the register early when bypassing is built in.
   function automatic logic eff_busy(input logic [1:0] cnt, input logic retiring);
      logic [1:0] eff;
      eff = cnt - {1'b0, BYPASS && retiring && cnt != 2'd0};
      return eff != 2'd0;
   endfunction

   assign rs_busy     = eff_busy(cnt_q[rs], wb_wen && wb_waddr == rs);
   assign rt_busy     = eff_busy(cnt_q[rt], wb_wen && wb_waddr == rt);
   assign hazard      = dec.legal && (rs_busy || (dec.is_r && rt_busy));
   assign instr_ready = !hazard;
   assign issue       = instr_valid && instr_ready;
   assign fire        = issue && dec.legal;

   always_comb begin
      aluop_cntrl  = 3'd0;
      alusrc_cntrl = 1'b0;
      rdata1       = '0;
      rdata2       = '0;
      signextender = '0;
      waddr        = '0;
      if (fire) begin
         aluop_cntrl  = dec.aluop;
         alusrc_cntrl = !dec.is_r;
         rdata1       = op1;
         rdata2       = op2;
         signextender = sext;
         waddr        = dst;
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         logic inc_r, dec_r;
         inc_r    = fire && r != 0 && dst == ASIZE'(r);
         dec_r    = wb_wen && wb_waddr == ASIZE'(r) && cnt_q[r] != 2'd0;
         cnt_d[r] = cnt_q[r] + {1'b0, inc_r} - {1'b0, dec_r};
      end
   end

   assign illegal_d = illegal_q | (issue && !dec.legal);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
         illegal_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: a reference model of an IF/ID/EXE/WB flow
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_id_decode_stage;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, rst;
   logic [31:0] instr;
   logic        instr_valid, instr_ready;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [2:0]  aluop_cntrl;
   logic        alusrc_cntrl;
   logic [31:0] rdata1, rdata2, signextender;
   logic [4:0]  waddr;
   logic        illegal_op;

   id_decode_stage dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .wb_wen       (wb_wen),
      .wb_waddr     (wb_waddr),
      .wb_wdata     (wb_wdata),
      .aluop_cntrl  (aluop_cntrl),
      .alusrc_cntrl (alusrc_cntrl),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .signextender (signextender),
      .waddr        (waddr),
      .illegal_op   (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  aluop;
      logic        alusrc;
      logic [31:0] rd1, rd2, sext;
      logic [4:0]  wa;
      logic        ready;
      logic        illegal;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: architectural registers plus the instruction in EXE and the write in WB.
   logic [31:0] m_regs [32];
   bit          ex_v, wb_v, wb_real, m_illegal, spur_en;
   logic [4:0]  ex_a, wb_a;
   logic [31:0] ex_d, wb_d;

   function automatic int ref_alu(input logic [31:0] ins);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         case (fn)
            6'h20: return 0;
            6'h22: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            default: return -1;
         endcase
      end
      case (op)
         6'h08: return 0;
         6'h0C: return 2;
         6'h0D: return 3;
         6'h0E: return 4;
         6'h0A: return 6;
         default: return -1;
      endcase
   endfunction

   function automatic bit busy(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (ex_v && ex_a == r) return 1'b1;
      return wb_real && wb_a == r && !BYP;
   endfunction

   function automatic logic [31:0] rd_val(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_v && wb_a == r) return wb_d;
      return m_regs[r];
   endfunction

   function automatic logic [31:0] alu(input int op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return ~(a | b);
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      ex_v = 0; wb_v = 0; wb_real = 0; m_illegal = 0;
      ex_a = 0; wb_a = 0; ex_d = 0; wb_d = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // One cycle: drive inputs, push the predicted outputs, advance the model after the edge.
   task automatic step(input logic [31:0] ins, input bit v, output bit issued);
      exp_t        e;
      int          op;
      bit          is_r, haz;
      logic [4:0]  rs, rt, rd, dst;
      logic [31:0] a, b, sx;
      wb_wen      = wb_v;
      wb_waddr    = wb_v ? wb_a : 5'd0;
      wb_wdata    = wb_v ? wb_d : 32'd0;
      instr       = ins;
      instr_valid = v;
      op   = ref_alu(ins);
      is_r = (ins[31:26] == 6'h00);
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      dst  = is_r ? rd : rt;
      sx   = {{16{ins[15]}}, ins[15:0]};
      a    = rd_val(rs);
      b    = rd_val(rt);
      haz  = (op >= 0) && (busy(rs) || (is_r && busy(rt)));
      issued = v && !haz;
      e.aluop = 3'd0; e.alusrc = 1'b0; e.rd1 = 32'd0; e.rd2 = 32'd0;
      e.sext = 32'd0; e.wa = 5'd0;
      e.ready   = !haz;
      e.illegal = m_illegal;
      if (issued && op >= 0) begin
         e.aluop  = 3'(op);
         e.alusrc = !is_r;
         e.rd1    = a;
         e.rd2    = b;
         e.sext   = sx;
         e.wa     = dst;
      end
      sb_q.push_back(e);
      $display("cyc t=%0t instr=%h v=%0d wb=%0d/%0d/%h ready_exp=%0d issue=%0d",
               $time, ins, v, wb_wen, wb_waddr, wb_wdata, e.ready, issued);
      @(posedge clk);
      #1;
      if (rst) begin
         if (wb_v && wb_a != 5'd0) m_regs[wb_a] = wb_d;
         if (issued && op < 0) m_illegal = 1'b1;
         wb_v = ex_v; wb_real = ex_v; wb_a = ex_a; wb_d = ex_d;
         ex_v = issued && op >= 0;
         ex_a = dst;
         ex_d = alu(op, a, is_r ? b : sx);
         // Stray writebacks to idle registers exercise the count floor and the bypass path.
         if (!wb_v && spur_en && $urandom_range(0, 3) == 0) begin
            wb_a = 5'($urandom_range(1, 7));
            if (!(ex_v && ex_a == wb_a)) begin
               wb_v = 1; wb_real = 0; wb_d = $urandom;
            end
         end
      end
   endtask

   task automatic issue(input logic [31:0] ins);
      bit ok;
      ok = 0;
      for (int k = 0; k < 8 && !ok; k++) step(ins, 1'b1, ok);
      if (!ok) begin
         n_bad++;
         $display("FAIL issue_timeout: instr %h not accepted within 8 cycles", ins);
      end
   endtask

   task automatic idle(input int n);
      bit d;
      for (int k = 0; k < n; k++) step(32'd0, 1'b0, d);
   endtask

   function automatic logic [31:0] rand_instr();
      int         k, s;
      logic [4:0] rs, rt, rd;
      logic [5:0] code;
      k  = $urandom_range(0, 29);
      s  = $urandom_range(0, 6);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      if (k == 0) return enc_i(6'h3F, rs, rt, 16'($urandom));
      if (k == 1) return enc_r(6'h21, rs, rt, rd);
      if (k < 16) begin
         case (s)
            0: code = 6'h20;
            1: code = 6'h22;
            2: code = 6'h24;
            3: code = 6'h25;
            4: code = 6'h26;
            5: code = 6'h27;
            default: code = 6'h2A;
         endcase
         return enc_r(code, rs, rt, rd);
      end
      case (s % 5)
         0: code = 6'h08;
         1: code = 6'h0C;
         2: code = 6'h0D;
         3: code = 6'h0E;
         default: code = 6'h0A;
      endcase
      return enc_i(code, rs, rt, 16'($urandom));
   endfunction

   always @(negedge clk) begin
      int mx;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         chk("instr_ready",  32'(instr_ready),  32'(mon_e.ready));
         chk("illegal_op",   32'(illegal_op),   32'(mon_e.illegal));
         chk("aluop_cntrl",  32'(aluop_cntrl),  32'(mon_e.aluop));
         chk("alusrc_cntrl", 32'(alusrc_cntrl), 32'(mon_e.alusrc));
         chk("rdata1",       rdata1,            mon_e.rd1);
         chk("rdata2",       rdata2,            mon_e.rd2);
         chk("signextender", signextender,      mon_e.sext);
         chk("waddr",        32'(waddr),        32'(mon_e.wa));
      end
      mx = 0;
      for (int r = 0; r < 32; r++) if (int'(dut.cnt_q[r]) > mx) mx = int'(dut.cnt_q[r]);
      chk("pending_count_le2", 32'(mx > 2), 32'd0);
   end

   initial begin
      logic [31:0] cur;
      bit          have, vld, iss;
      rst = 1'b0; instr = 32'd0; instr_valid = 1'b0;
      wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
      spur_en = 0;
      model_clear();
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b1;
      idle(1);

      issue(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
      issue(enc_r(6'h20, 5'd1, 5'd1, 5'd3));
      idle(3);

      issue(enc_i(6'h0C, 5'd0, 5'd2, 16'hFFFF));
      issue(enc_i(6'h0A, 5'd0, 5'd7, 16'h8000));
      idle(3);

      issue(enc_i(6'h08, 5'd0, 5'd4, 16'd1));
      issue(enc_i(6'h08, 5'd0, 5'd4, 16'd2));
      issue(enc_r(6'h20, 5'd4, 5'd4, 5'd5));
      idle(3);
      issue(enc_i(6'h08, 5'd0, 5'd4, 16'd3));
      idle(1);
      issue(enc_i(6'h08, 5'd0, 5'd4, 16'd9));
      issue(enc_r(6'h22, 5'd4, 5'd0, 5'd6));
      idle(3);

      issue({6'h3F, 26'h0});
      issue(enc_i(6'h08, 5'd1, 5'd1, 16'd1));
      idle(2);

      spur_en = 1;
      have = 0;
      cur  = 32'd0;
      repeat (400) begin
         if (!have) begin
            cur  = rand_instr();
            have = 1;
         end
         vld = ($urandom_range(0, 4) != 0);
         step(cur, vld, iss);
         if (iss) have = 0;
      end
      spur_en = 0;
      idle(3);

      issue(enc_i(6'h08, 5'd0, 5'd5, 16'd7));
      #2 rst = 1'b0;
      model_clear();
      idle(2);
      #2 rst = 1'b1;
      issue(enc_r(6'h20, 5'd5, 5'd5, 5'd6));
      idle(3);

      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
